// File: rtl/alt_ddrx_ecc_err_logger.sv
// ECC error logger for the DDR read datapath.
// Classifies each decoded read beat as a correctable (sbe) or uncorrectable
// (dbe) error. It keeps saturating counts of both, captures the most relevant
// error address, raises a sticky interrupt, and issues scrub (read-modify-write)
// requests for corrected addresses. The scrub path has one request in flight
// plus one pending slot.
// Ports:
//   ctl_clk, ctl_reset_n          clock, async active-low reset
//   ecc_enable                    qualifies all error inputs
//   rdata_valid, rdata_addr       decoded beat strobe and its local address
//   err_detected/corrected/fatal  decoder status for the beat
//   intr_enable, clr_intr         interrupt enable / clear pulse
//   clr_counters                  clears counters and captured address
//   sbe_count, dbe_count          saturating error counters
//   err_addr[_valid,_is_dbe]      captured error address and type
//   ecc_interrupt, scrub_overflow sticky status flags
//   scrub_req, scrub_addr, scrub_ack  scrub request handshake
module alt_ddrx_ecc_err_logger #(
  parameter int ADDR_WIDTH = 25,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  ctl_clk,
  input  logic                  ctl_reset_n,
  input  logic                  ecc_enable,
  input  logic                  rdata_valid,
  input  logic [ADDR_WIDTH-1:0] rdata_addr,
  input  logic                  err_detected,
  input  logic                  err_corrected,
  input  logic                  err_fatal,
  input  logic                  intr_enable,
  input  logic                  clr_counters,
  input  logic                  clr_intr,
  output logic [CNT_WIDTH-1:0]  sbe_count,
  output logic [CNT_WIDTH-1:0]  dbe_count,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_addr_valid,
  output logic                  err_addr_is_dbe,
  output logic                  ecc_interrupt,
  output logic                  scrub_overflow,
  output logic                  scrub_req,
  output logic [ADDR_WIDTH-1:0] scrub_addr,
  input  logic                  scrub_ack
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} scrub_st_t;

  scrub_st_t             state;
  logic                  pend_valid;
  logic [ADDR_WIDTH-1:0] pend_addr;

  logic beat_err, sbe, dbe, any_err, ovf_evt;

  // Fatal dominates: a beat flagged both corrected and fatal is a dbe only.
  assign beat_err = ecc_enable & rdata_valid & err_detected;
  assign dbe      = beat_err & err_fatal;
  assign sbe      = beat_err & err_corrected & ~err_fatal;
  assign any_err  = sbe | dbe;

  // Drop happens only when both slots are busy and nothing frees one this cycle.
  assign ovf_evt  = sbe & (state == REQ) & pend_valid & ~scrub_ack;

  assign scrub_req = (state == REQ);

  // Counters
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      sbe_count <= '0;
      dbe_count <= '0;
    end else if (clr_counters) begin
      sbe_count <= sbe ? CNT_ONE : '0;
      dbe_count <= dbe ? CNT_ONE : '0;
    end else begin
      if (sbe && sbe_count != CNT_MAX) sbe_count <= sbe_count + CNT_ONE;
      if (dbe && dbe_count != CNT_MAX) dbe_count <= dbe_count + CNT_ONE;
    end
  end

  // Error address capture: first error wins, a later dbe may upgrade an sbe.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      err_addr        <= '0;
      err_addr_valid  <= 1'b0;
      err_addr_is_dbe <= 1'b0;
    end else if (clr_counters) begin
      err_addr_valid  <= 1'b0;
      err_addr_is_dbe <= 1'b0;
    end else if (!err_addr_valid && any_err) begin
      err_addr        <= rdata_addr;
      err_addr_valid  <= 1'b1;
      err_addr_is_dbe <= dbe;
    end else if (err_addr_valid && !err_addr_is_dbe && dbe) begin
      err_addr        <= rdata_addr;
      err_addr_is_dbe <= 1'b1;
    end
  end

  // Sticky flags: a new set event beats a coincident clear.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      ecc_interrupt  <= 1'b0;
      scrub_overflow <= 1'b0;
    end else begin
      if (intr_enable && any_err) ecc_interrupt <= 1'b1;
      else if (clr_intr)          ecc_interrupt <= 1'b0;
      if (ovf_evt)                scrub_overflow <= 1'b1;
      else if (clr_intr)          scrub_overflow <= 1'b0;
    end
  end

  // Scrub request FSM with one pending slot.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      state      <= IDLE;
      scrub_addr <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sbe) begin
            scrub_addr <= rdata_addr;
            state      <= REQ;
          end
        end
        REQ: begin
          if (scrub_ack) begin
            if (pend_valid) begin
              scrub_addr <= pend_addr;
              // A same-cycle sbe refills the slot the promotion just freed.
              if (sbe) pend_addr  <= rdata_addr;
              else     pend_valid <= 1'b0;
            end else if (sbe) begin
              // Slot empty and current request retiring: issue the new one directly.
              scrub_addr <= rdata_addr;
            end else begin
              state <= IDLE;
            end
          end else if (sbe && !pend_valid) begin
            pend_addr  <= rdata_addr;
            pend_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alt_ddrx_ecc_err_logger.sv
module tb_alt_ddrx_ecc_err_logger;
  localparam int AW = 25;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic ctl_clk = 1'b0, ctl_reset_n = 1'b0;
  logic ecc_enable = 0, rdata_valid = 0, err_detected = 0, err_corrected = 0, err_fatal = 0;
  logic intr_enable = 0, clr_counters = 0, clr_intr = 0, scrub_ack = 0;
  logic [AW-1:0] rdata_addr = '0;
  logic [CW-1:0] sbe_count, dbe_count;
  logic [AW-1:0] err_addr, scrub_addr;
  logic err_addr_valid, err_addr_is_dbe, ecc_interrupt, scrub_overflow, scrub_req;

  alt_ddrx_ecc_err_logger #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .ctl_clk(ctl_clk), .ctl_reset_n(ctl_reset_n), .ecc_enable(ecc_enable),
    .rdata_valid(rdata_valid), .rdata_addr(rdata_addr), .err_detected(err_detected),
    .err_corrected(err_corrected), .err_fatal(err_fatal), .intr_enable(intr_enable),
    .clr_counters(clr_counters), .clr_intr(clr_intr), .sbe_count(sbe_count),
    .dbe_count(dbe_count), .err_addr(err_addr), .err_addr_valid(err_addr_valid),
    .err_addr_is_dbe(err_addr_is_dbe), .ecc_interrupt(ecc_interrupt),
    .scrub_overflow(scrub_overflow), .scrub_req(scrub_req), .scrub_addr(scrub_addr),
    .scrub_ack(scrub_ack));

  always #5 ctl_clk = ~ctl_clk;

  typedef struct {
    int sc, dc;
    logic [AW-1:0] ea, sa;
    bit ev, edbe, intr, ovf, req;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0, checks = 0;

  // Reference model: counts, captured address, flags, and the scrub work list
  // (front = address currently requested, at most one waiting behind it).
  int m_sc, m_dc;
  logic [AW-1:0] m_ea;
  bit m_ev, m_edbe, m_intr, m_ovf;
  logic [AW-1:0] m_work[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sc = 0; m_dc = 0; m_ea = '0; m_ev = 0; m_edbe = 0; m_intr = 0; m_ovf = 0;
    m_work.delete();
  endtask

  // Apply the current inputs to the model and queue the expected outputs.
  task automatic model_step();
    bit is_sbe, is_dbe, drop;
    exp_t e;
    is_dbe = ecc_enable && rdata_valid && err_detected && err_fatal;
    is_sbe = ecc_enable && rdata_valid && err_detected && err_corrected && !err_fatal;
    drop = 0;
    if (clr_counters) begin
      m_sc = is_sbe ? 1 : 0; m_dc = is_dbe ? 1 : 0; m_ev = 0; m_edbe = 0;
    end else begin
      if (is_sbe) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
      if (is_dbe) m_dc = (m_dc < CMAX) ? m_dc + 1 : CMAX;
      if (!m_ev && (is_sbe || is_dbe)) begin
        m_ea = rdata_addr; m_ev = 1; m_edbe = is_dbe;
      end else if (m_ev && !m_edbe && is_dbe) begin
        m_ea = rdata_addr; m_edbe = 1;
      end
    end
    if (scrub_ack && m_work.size() > 0) void'(m_work.pop_front());
    if (is_sbe) begin
      if (m_work.size() < 2) m_work.push_back(rdata_addr);
      else drop = 1;
    end
    if (intr_enable && (is_sbe || is_dbe)) m_intr = 1;
    else if (clr_intr) m_intr = 0;
    if (drop) m_ovf = 1;
    else if (clr_intr) m_ovf = 0;
    e.sc = m_sc; e.dc = m_dc; e.ea = m_ea; e.ev = m_ev; e.edbe = m_edbe;
    e.intr = m_intr; e.ovf = m_ovf; e.req = (m_work.size() > 0);
    e.sa = e.req ? m_work[0] : '0;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: drive at negedge, return just after the next posedge.
  task automatic step(input bit v, input logic [AW-1:0] a, input bit det, input bit cor,
                      input bit fat, input bit ack, input bit cc, input bit ci);
    @(negedge ctl_clk);
    rdata_valid = v; rdata_addr = a; err_detected = det; err_corrected = cor;
    err_fatal = fat; scrub_ack = ack; clr_counters = cc; clr_intr = ci;
    model_step();
    @(posedge ctl_clk);
    #2;
  endtask

  task automatic idle_inputs();
    rdata_valid = 0; err_detected = 0; err_corrected = 0; err_fatal = 0;
    scrub_ack = 0; clr_counters = 0; clr_intr = 0;
  endtask

  task automatic drain_and_clear();
    for (int i = 0; i < 4 && m_work.size() > 0; i++) step(0, '0, 0, 0, 0, 1, 0, 0);
    step(0, '0, 0, 0, 0, 0, 1, 1);
  endtask

  // Monitor: registered outputs are checked one cycle after each stimulus beat.
  initial begin
    exp_t e;
    forever begin
      @(posedge ctl_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sbe_count", sbe_count, e.sc);
        chk("dbe_count", dbe_count, e.dc);
        chk("err_addr_valid", err_addr_valid, e.ev);
        chk("err_addr_is_dbe", err_addr_is_dbe, e.edbe);
        if (e.ev) chk("err_addr", err_addr, e.ea);
        chk("ecc_interrupt", ecc_interrupt, e.intr);
        chk("scrub_overflow", scrub_overflow, e.ovf);
        chk("scrub_req", scrub_req, e.req);
        if (e.req) chk("scrub_addr", scrub_addr, e.sa);
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    model_reset();
    repeat (3) @(posedge ctl_clk);
    #2;
    chk("reset_sbe_count", sbe_count, 0);
    chk("reset_scrub_req", scrub_req, 0);
    chk("reset_err_valid", err_addr_valid, 0);
    chk("reset_intr", ecc_interrupt, 0);
    @(negedge ctl_clk);
    ctl_reset_n = 1;
    ecc_enable = 1;

    // Three back-to-back sbe beats before any ack: third address dropped.
    step(1, 25'h10, 1, 1, 0, 0, 0, 0);
    step(1, 25'h20, 1, 1, 0, 0, 0, 0);
    step(1, 25'h30, 1, 1, 0, 0, 0, 0);
    chk("d1_sbe_count", sbe_count, 3);
    chk("d1_err_addr", err_addr, 25'h10);
    chk("d1_is_dbe", err_addr_is_dbe, 0);
    chk("d1_scrub_addr", scrub_addr, 25'h10);
    chk("d1_overflow", scrub_overflow, 1);
    step(0, '0, 0, 0, 0, 1, 0, 0);
    chk("d1_scrub_addr_after_ack", scrub_addr, 25'h20);
    chk("d1_scrub_req_after_ack", scrub_req, 1);
    step(0, '0, 0, 0, 0, 1, 0, 0);
    chk("d1_scrub_idle", scrub_req, 0);
    drain_and_clear();

    // sbe then dbe: dbe upgrades the captured address, never scrubbed.
    step(1, 25'h40, 1, 1, 0, 0, 0, 0);
    step(1, 25'h50, 1, 0, 1, 0, 0, 0);
    chk("d2_err_addr", err_addr, 25'h50);
    chk("d2_is_dbe", err_addr_is_dbe, 1);
    chk("d2_dbe_count", dbe_count, 1);
    chk("d2_scrub_addr", scrub_addr, 25'h40);
    step(0, '0, 0, 0, 0, 1, 0, 0);
    chk("d2_no_scrub_for_dbe", scrub_req, 0);
    drain_and_clear();

    // Saturation, then clear with a coincident sbe.
    for (int i = 0; i < 300; i++) step(1, AW'(i), 1, 1, 0, 1, 0, 0);
    chk("d3_saturate", sbe_count, CMAX);
    step(1, 25'h77, 1, 1, 0, 1, 1, 0);
    chk("d3_clear_coincident", sbe_count, 1);
    drain_and_clear();

    // Interrupt set beats clear; disabled ECC ignores errors.
    intr_enable = 1;
    step(1, 25'h60, 1, 0, 1, 0, 0, 1);
    chk("d4_intr_set_wins", ecc_interrupt, 1);
    step(0, '0, 0, 0, 0, 0, 1, 1);
    ecc_enable = 0;
    step(1, 25'h61, 1, 1, 0, 0, 0, 0);
    step(1, 25'h62, 1, 0, 1, 0, 0, 0);
    chk("d4_disabled_sbe", sbe_count, 0);
    chk("d4_disabled_dbe", dbe_count, 0);
    chk("d4_disabled_intr", ecc_interrupt, 0);
    ecc_enable = 1;

    // Randomized traffic; clears only on idle beats.
    for (int i = 0; i < 500; i++) begin
      bit v, cc;
      v = ($urandom_range(0, 3) != 0);
      cc = !v && ($urandom_range(0, 15) == 0);
      ecc_enable = ($urandom_range(0, 9) != 0);
      intr_enable = $urandom_range(0, 1);
      step(v, AW'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), cc,
           ($urandom_range(0, 7) == 0));
    end
    ecc_enable = 1;
    drain_and_clear();

    // Reset in the middle of a handshake with a pending entry.
    step(1, 25'h100, 1, 1, 0, 0, 0, 0);
    step(1, 25'h200, 1, 1, 0, 0, 0, 0);
    chk("d5_req_before_reset", scrub_req, 1);
    #1;
    ctl_reset_n = 0;
    #1;
    chk("d5_reset_scrub_req", scrub_req, 0);
    chk("d5_reset_sbe_count", sbe_count, 0);
    chk("d5_reset_dbe_count", dbe_count, 0);
    chk("d5_reset_ovf", scrub_overflow, 0);
    model_reset();
    idle_inputs();
    @(negedge ctl_clk);
    ctl_reset_n = 1;
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 0, 1, 0, 0);
    chk("d5_ack_ignored_idle", scrub_req, 0);
    step(1, 25'h300, 1, 1, 0, 0, 0, 0);
    chk("d5_fresh_request", scrub_addr, 25'h300);

    if (exp_q.size() != 0) chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
